// File: rtl/mem_req_ctrl.sv
// Memory request controller: arbitrates icache/dcache line requests onto a
// single memory port, tracks one outstanding fill, and flags lost or
// unexpected memory responses.

package params_pkg;
    localparam int ADDR_WIDTH = 32;

    typedef logic [2:0] access_size_t;

    localparam access_size_t ACC_BYTE  = 3'd0;
    localparam access_size_t ACC_HALF  = 3'd1;
    localparam access_size_t ACC_WORD  = 3'd2;
    localparam access_size_t ACC_DWORD = 3'd3;
    localparam access_size_t ACC_LINE  = 3'd4;
endpackage

module mem_req_ctrl #(
    parameter int                     ADDR_WIDTH       = params_pkg::ADDR_WIDTH,
    parameter int                     LINE_WIDTH       = 128,
    parameter int                     MEM_LATENCY      = 10,
    parameter int                     TIMEOUT          = 32,
    parameter params_pkg::access_size_t LINE_ACCESS_SIZE = params_pkg::ACC_LINE
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ic_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]    ic_req_addr_i,
    output logic                     ic_req_ready_o,
    output logic                     ic_resp_valid_o,
    output logic [LINE_WIDTH-1:0]    ic_resp_data_o,
    input  logic                     dc_req_valid_i,
    input  logic                     dc_req_is_wr_i,
    input  logic [ADDR_WIDTH-1:0]    dc_req_addr_i,
    input  logic [LINE_WIDTH-1:0]    dc_req_wr_data_i,
    output logic                     dc_req_ready_o,
    output logic                     dc_resp_valid_o,
    output logic [LINE_WIDTH-1:0]    dc_resp_data_o,
    output logic                     mem_rd_req_valid_o,
    output logic                     mem_wr_req_valid_o,
    output logic                     mem_req_is_instr_o,
    output logic [ADDR_WIDTH-1:0]    mem_address_o,
    output logic [LINE_WIDTH-1:0]    mem_wr_data_o,
    output params_pkg::access_size_t mem_access_size_o,
    input  logic                     mem_data_valid_i,
    input  logic                     mem_data_is_instr_i,
    input  logic [LINE_WIDTH-1:0]    mem_data_i,
    output logic                     timeout_err_o,
    output logic                     spurious_err_o
);

    typedef enum logic [1:0] {S_DRAIN, S_IDLE, S_ISSUE, S_WAIT_RD} state_e;

    // One counter serves both the post-reset drain and the fill timeout.
    localparam int CNT_MAX = (MEM_LATENCY > TIMEOUT) ? MEM_LATENCY : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(MEM_LATENCY);
    localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT - 1);

    state_e                   state_q;
    logic [CW-1:0]            cnt_q;
    logic                     prio_dc_q;
    logic                     ic_resp_valid_q, dc_resp_valid_q;
    logic [LINE_WIDTH-1:0]    ic_resp_data_q, dc_resp_data_q;
    logic                     mem_rd_q, mem_wr_q, mem_instr_q;
    logic [ADDR_WIDTH-1:0]    mem_addr_q;
    logic [LINE_WIDTH-1:0]    mem_wdata_q;
    params_pkg::access_size_t mem_size_q;
    logic                     tmo_q, spur_q;

    logic gnt_dc, gnt_ic, accept, rsp_match;

    // Round-robin grant; a lone requester always wins regardless of pointer.
    assign gnt_dc    = dc_req_valid_i & (prio_dc_q | ~ic_req_valid_i);
    assign gnt_ic    = ic_req_valid_i & ~gnt_dc;
    assign ic_req_ready_o = (state_q == S_IDLE) & gnt_ic;
    assign dc_req_ready_o = (state_q == S_IDLE) & gnt_dc;
    assign accept    = ic_req_ready_o | dc_req_ready_o;
    assign rsp_match = (state_q == S_WAIT_RD) & mem_data_valid_i &
                       (mem_data_is_instr_i == mem_instr_q);

    // Controller FSM with all memory/response outputs registered.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q         <= S_DRAIN;
            cnt_q           <= '0;
            prio_dc_q       <= 1'b1;
            ic_resp_valid_q <= 1'b0;
            dc_resp_valid_q <= 1'b0;
            ic_resp_data_q  <= '0;
            dc_resp_data_q  <= '0;
            mem_rd_q        <= 1'b0;
            mem_wr_q        <= 1'b0;
            mem_instr_q     <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_size_q      <= '0;
            tmo_q           <= 1'b0;
            spur_q          <= 1'b0;
        end else begin
            ic_resp_valid_q <= 1'b0;
            dc_resp_valid_q <= 1'b0;
            mem_rd_q        <= 1'b0;
            mem_wr_q        <= 1'b0;
            // Any read data outside a matching WAIT_RD slot is unexpected,
            // except during drain where stale responses are absorbed.
            if (mem_data_valid_i && state_q != S_DRAIN && !rsp_match)
                spur_q <= 1'b1;
            case (state_q)
                S_DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        state_q     <= S_ISSUE;
                        prio_dc_q   <= gnt_ic;
                        mem_instr_q <= gnt_ic;
                        mem_addr_q  <= gnt_ic ? ic_req_addr_i : dc_req_addr_i;
                        if (gnt_dc) mem_wdata_q <= dc_req_wr_data_i;
                        mem_wr_q    <= gnt_dc & dc_req_is_wr_i;
                        mem_rd_q    <= ~(gnt_dc & dc_req_is_wr_i);
                        mem_size_q  <= LINE_ACCESS_SIZE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= mem_wr_q ? S_IDLE : S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    if (rsp_match) begin
                        state_q <= S_IDLE;
                        if (mem_instr_q) begin
                            ic_resp_valid_q <= 1'b1;
                            ic_resp_data_q  <= mem_data_i;
                        end else begin
                            dc_resp_valid_q <= 1'b1;
                            dc_resp_data_q  <= mem_data_i;
                        end
                    end else if (cnt_q == TMO_LAST) begin
                        tmo_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_DRAIN;
            endcase
        end
    end

    assign ic_resp_valid_o    = ic_resp_valid_q;
    assign ic_resp_data_o     = ic_resp_data_q;
    assign dc_resp_valid_o    = dc_resp_valid_q;
    assign dc_resp_data_o     = dc_resp_data_q;
    assign mem_rd_req_valid_o = mem_rd_q;
    assign mem_wr_req_valid_o = mem_wr_q;
    assign mem_req_is_instr_o = mem_instr_q;
    assign mem_address_o      = mem_addr_q;
    assign mem_wr_data_o      = mem_wdata_q;
    assign mem_access_size_o  = mem_size_q;
    assign timeout_err_o      = tmo_q;
    assign spurious_err_o     = spur_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: arbitration table plus hand-timed
// fill/writeback/timeout/spurious/reset sequences.

module tb_mem_req_ctrl;
    localparam int AW  = 32;
    localparam int LW  = 128;
    localparam int LAT = 10;
    localparam int TMO = 32;

    logic clk_i = 1'b0;
    logic rst_i;
    logic ic_req_valid_i, ic_req_ready_o, ic_resp_valid_o;
    logic [AW-1:0] ic_req_addr_i;
    logic [LW-1:0] ic_resp_data_o;
    logic dc_req_valid_i, dc_req_is_wr_i, dc_req_ready_o, dc_resp_valid_o;
    logic [AW-1:0] dc_req_addr_i;
    logic [LW-1:0] dc_req_wr_data_i, dc_resp_data_o;
    logic mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o;
    logic [AW-1:0] mem_address_o;
    logic [LW-1:0] mem_wr_data_o;
    params_pkg::access_size_t mem_access_size_o;
    logic mem_data_valid_i, mem_data_is_instr_i;
    logic [LW-1:0] mem_data_i;
    logic timeout_err_o, spurious_err_o;

    mem_req_ctrl #(
        .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MEM_LATENCY(LAT), .TIMEOUT(TMO),
        .LINE_ACCESS_SIZE(params_pkg::ACC_LINE)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i),
        .ic_req_ready_o(ic_req_ready_o), .ic_resp_valid_o(ic_resp_valid_o),
        .ic_resp_data_o(ic_resp_data_o),
        .dc_req_valid_i(dc_req_valid_i), .dc_req_is_wr_i(dc_req_is_wr_i),
        .dc_req_addr_i(dc_req_addr_i), .dc_req_wr_data_i(dc_req_wr_data_i),
        .dc_req_ready_o(dc_req_ready_o), .dc_resp_valid_o(dc_resp_valid_o),
        .dc_resp_data_o(dc_resp_data_o),
        .mem_rd_req_valid_o(mem_rd_req_valid_o), .mem_wr_req_valid_o(mem_wr_req_valid_o),
        .mem_req_is_instr_o(mem_req_is_instr_o), .mem_address_o(mem_address_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_access_size_o(mem_access_size_o),
        .mem_data_valid_i(mem_data_valid_i), .mem_data_is_instr_i(mem_data_is_instr_i),
        .mem_data_i(mem_data_i),
        .timeout_err_o(timeout_err_o), .spurious_err_o(spurious_err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic ic_v;
        logic dc_v;
        logic ic_rdy;
        logic dc_rdy;
    } arb_vec_t;

    arb_vec_t arb_tbl[4];

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Request already driven in the current cycle; walks it through
    // accept, ISSUE, memory latency and the response pulse (ends cycle 12).
    task automatic run_fill(input bit ic, input logic [AW-1:0] addr,
                            input logic [LW-1:0] data, input string nm);
        #1;
        chk({nm, ":ready"}, ic ? ic_req_ready_o : dc_req_ready_o, 1);
        step();
        if (ic) ic_req_valid_i = 1'b0; else dc_req_valid_i = 1'b0;
        chk({nm, ":rd_pulse"}, mem_rd_req_valid_o, 1);
        chk({nm, ":wr_low"}, mem_wr_req_valid_o, 0);
        chk({nm, ":tag"}, mem_req_is_instr_o, ic);
        chk({nm, ":addr"}, mem_address_o, addr);
        chk({nm, ":size"}, mem_access_size_o, params_pkg::ACC_LINE);
        step();
        chk({nm, ":rd_one_cycle"}, mem_rd_req_valid_o, 0);
        repeat (LAT - 1) step();
        chk({nm, ":no_early_resp"}, {ic_resp_valid_o, dc_resp_valid_o}, 0);
        mem_data_valid_i    = 1'b1;
        mem_data_is_instr_i = ic;
        mem_data_i          = data;
        step();
        mem_data_valid_i = 1'b0;
        chk({nm, ":resp_valid"}, ic ? ic_resp_valid_o : dc_resp_valid_o, 1);
        chk({nm, ":other_resp"}, ic ? dc_resp_valid_o : ic_resp_valid_o, 0);
        chk({nm, ":resp_data"}, ic ? ic_resp_data_o : dc_resp_data_o, data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [LW-1:0] a5, d0, c3, wb, dd;
        logic any_rdy, any_resp;
        a5 = {16{8'hA5}};
        d0 = {16{8'hD0}};
        c3 = {16{8'hC3}};
        wb = {8{16'h1234}};
        dd = {16{8'h5A}};

        arb_tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        arb_tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        arb_tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
        arb_tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1};

        ic_req_valid_i = 0; ic_req_addr_i = '0;
        dc_req_valid_i = 0; dc_req_is_wr_i = 0; dc_req_addr_i = '0; dc_req_wr_data_i = '0;
        mem_data_valid_i = 0; mem_data_is_instr_i = 0; mem_data_i = '0;

        // Asynchronous reset values
        rst_i = 1'b1;
        #2 rst_i = 1'b0;
        #1;
        chk("rst:ready", {ic_req_ready_o, dc_req_ready_o}, 0);
        chk("rst:valids", {mem_rd_req_valid_o, mem_wr_req_valid_o, ic_resp_valid_o, dc_resp_valid_o}, 0);
        chk("rst:errs", {timeout_err_o, spurious_err_o}, 0);
        chk("rst:addr", mem_address_o, 0);
        chk("rst:data", ic_resp_data_o | dc_resp_data_o | mem_wr_data_o, 0);
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;

        // DRAIN lasts LAT+1 cycles and ignores memory data
        ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h40;
        any_rdy = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            step();
            any_rdy |= ic_req_ready_o | dc_req_ready_o;
            mem_data_valid_i = (i == 3);
        end
        chk("drain:ready_low", any_rdy, 0);
        chk("drain:no_spurious", spurious_err_o, 0);
        step();
        chk("drain:exit_ready", ic_req_ready_o, 1);
        ic_req_valid_i = 1'b0;

        // Arbitration table in IDLE, pointer at dcache, no accepts
        foreach (arb_tbl[k]) begin
            step();
            ic_req_valid_i = arb_tbl[k].ic_v;
            dc_req_valid_i = arb_tbl[k].dc_v;
            #1;
            chk($sformatf("arb%0d:ic_rdy", k), ic_req_ready_o, arb_tbl[k].ic_rdy);
            chk($sformatf("arb%0d:dc_rdy", k), dc_req_ready_o, arb_tbl[k].dc_rdy);
            ic_req_valid_i = 1'b0;
            dc_req_valid_i = 1'b0;
        end

        // Icache fill 0x40
        step();
        ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h40;
        run_fill(1'b1, 32'h40, a5, "ic_fill");
        chk("ic_fill:errs", {timeout_err_o, spurious_err_o}, 0);
        step();
        chk("ic_fill:pulse_once", ic_resp_valid_o, 0);
        chk("ic_fill:data_hold", ic_resp_data_o, a5);

        // Tie: dcache wins, icache served on the following IDLE
        dc_req_valid_i = 1'b1; dc_req_is_wr_i = 1'b0; dc_req_addr_i = 32'h100;
        ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h140;
        #1 chk("tie:ic_waits", ic_req_ready_o, 0);
        run_fill(1'b0, 32'h100, d0, "tie_dc");
        run_fill(1'b1, 32'h140, c3, "tie_ic");

        // Writeback then fill of the same line
        dc_req_valid_i = 1'b1; dc_req_is_wr_i = 1'b1;
        dc_req_addr_i = 32'h80; dc_req_wr_data_i = wb;
        #1 chk("wb:ready", dc_req_ready_o, 1);
        step();
        chk("wb:wr_pulse", mem_wr_req_valid_o, 1);
        chk("wb:rd_low", mem_rd_req_valid_o, 0);
        chk("wb:addr", mem_address_o, 32'h80);
        chk("wb:data", mem_wr_data_o, wb);
        dc_req_is_wr_i = 1'b0;
        #1 chk("wb:issue_busy", dc_req_ready_o, 0);
        step();
        run_fill(1'b0, 32'h80, wb, "wb_fill");

        // Spurious response in IDLE
        chk("spur:pre", spurious_err_o, 0);
        mem_data_valid_i = 1'b1; mem_data_is_instr_i = 1'b1; mem_data_i = dd;
        step();
        mem_data_valid_i = 1'b0;
        chk("spur:set", spurious_err_o, 1);
        chk("spur:no_resp", {ic_resp_valid_o, dc_resp_valid_o}, 0);
        step();
        chk("spur:data_held", ic_resp_data_o, c3);

        // Silent memory: timeout after TMO WAIT_RD cycles
        ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h200;
        #1 chk("tmo:ready", ic_req_ready_o, 1);
        step();
        ic_req_valid_i = 1'b0;
        step();
        repeat (TMO - 1) step();
        chk("tmo:not_yet", timeout_err_o, 0);
        step();
        chk("tmo:set", timeout_err_o, 1);
        chk("tmo:no_resp", ic_resp_valid_o, 0);
        dc_req_valid_i = 1'b1; dc_req_is_wr_i = 1'b1; dc_req_addr_i = 32'h240;
        #1 chk("tmo:next_accept", dc_req_ready_o, 1);
        step();
        dc_req_valid_i = 1'b0;
        chk("tmo:next_wr", mem_wr_req_valid_o, 1);
        chk("tmo:spur_sticky", spurious_err_o, 1);

        // Reset in the middle of WAIT_RD, late response during drain
        step();
        ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h300;
        step();
        ic_req_valid_i = 1'b0;
        repeat (4) step();
        rst_i = 1'b0;
        #1;
        chk("rst_mid:errs", {timeout_err_o, spurious_err_o}, 0);
        chk("rst_mid:outs", {mem_rd_req_valid_o, ic_req_ready_o, ic_resp_valid_o}, 0);
        step();
        rst_i = 1'b1;
        any_resp = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            step();
            any_resp |= ic_resp_valid_o | dc_resp_valid_o;
            mem_data_valid_i = (i == 2);
            mem_data_is_instr_i = 1'b1;
            mem_data_i = dd;
        end
        step();
        any_resp |= ic_resp_valid_o | dc_resp_valid_o;
        chk("rst_mid:no_pulse", any_resp, 0);
        chk("rst_mid:no_spur", spurious_err_o, 0);

        // Mismatched tag in WAIT_RD is spurious; matching one still completes
        dc_req_valid_i = 1'b1; dc_req_is_wr_i = 1'b0; dc_req_addr_i = 32'h500;
        #1 chk("mis:ready", dc_req_ready_o, 1);
        step();
        dc_req_valid_i = 1'b0;
        repeat (3) step();
        mem_data_valid_i = 1'b1; mem_data_is_instr_i = 1'b1; mem_data_i = dd;
        step();
        mem_data_valid_i = 1'b0;
        chk("mis:spur", spurious_err_o, 1);
        chk("mis:no_resp", {ic_resp_valid_o, dc_resp_valid_o}, 0);
        repeat (6) step();
        mem_data_valid_i = 1'b1; mem_data_is_instr_i = 1'b0; mem_data_i = d0;
        step();
        mem_data_valid_i = 1'b0;
        chk("mis:dc_resp", dc_resp_valid_o, 1);
        chk("mis:dc_data", dc_resp_data_o, d0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default params_pkg::ADDR_WIDTH, memory byte-address width.
REQ-002 Parameter LINE_WIDTH, default 128, line data width in bits.
REQ-003 Parameter MEM_LATENCY, default 10, memory request-to-data_valid latency in cycles.
REQ-004 Parameter TIMEOUT, default 32, maximum WAIT_RD cycles before error.
REQ-005 Parameter LINE_ACCESS_SIZE, type access_size_t, value driven on mem_access_size_o.
REQ-006 Clocking: one clock, clk_i; reset rst_i is asynchronous and active-low.
REQ-007 Ports, in order:
 clk_i  in  1  clock
 rst_i  in  1  async active-low reset
 ic_req_valid_i  in  1  icache line-fill request
 ic_req_addr_i  in  ADDR_WIDTH  icache fill address
 ic_req_ready_o  out  1  icache request accepted this cycle
 ic_resp_valid_o  out  1  icache fill data valid (1-cycle pulse)
 ic_resp_data_o  out  LINE_WIDTH  icache fill data
 dc_req_valid_i  in  1  dcache request
 dc_req_is_wr_i  in  1  1 = writeback, 0 = fill
 dc_req_addr_i  in  ADDR_WIDTH  dcache address
 dc_req_wr_data_i  in  LINE_WIDTH  writeback data
 dc_req_ready_o  out  1  dcache request accepted this cycle
 dc_resp_valid_o  out  1  dcache fill data valid (1-cycle pulse)
 dc_resp_data_o  out  LINE_WIDTH  dcache fill data
 mem_rd_req_valid_o  out  1  memory read request
 mem_wr_req_valid_o  out  1  memory write request
 mem_req_is_instr_o  out  1  request tag, 1 = icache
 mem_address_o  out  ADDR_WIDTH  memory address
 mem_wr_data_o  out  LINE_WIDTH  memory write data
 mem_access_size_o  out  access_size_t  access size
 mem_data_valid_i  in  1  memory read data valid
 mem_data_is_instr_i  in  1  returned tag
 mem_data_i  in  LINE_WIDTH  returned data
 timeout_err_o  out  1  sticky: read response missing
 spurious_err_o  out  1  sticky: unexpected read response

Function
REQ-008 FSM states DRAIN, IDLE, ISSUE, WAIT_RD; all mem_* and *_resp_* outputs registered.
REQ-009 DRAIN: both ready low, all mem_data_valid_i ignored without error; exits to IDLE after exactly MEM_LATENCY+1 cycles following reset release.
REQ-010 IDLE: exactly one of ic_req_ready_o/dc_req_ready_o high, for the granted requester with valid high; accept = valid & ready; accept -> ISSUE.
REQ-011 Arbitration round-robin: both valid -> grant requester not granted last; pointer updates only on accept; after reset dcache wins first tie.
REQ-012 Requesters hold valid and payload stable until ready; dropping valid before accept withdraws the request without effect.
REQ-013 ISSUE lasts one cycle: exactly one of mem_rd_req_valid_o/mem_wr_req_valid_o high with captured address/data, mem_req_is_instr_o = 1 for icache, mem_access_size_o = LINE_ACCESS_SIZE; mem valids low in all other states.
REQ-014 ISSUE -> IDLE for writeback (no response returned), ISSUE -> WAIT_RD for fill.
REQ-015 WAIT_RD: mem_data_valid_i with tag matching outstanding requester -> next cycle 1-cycle resp_valid pulse to that requester with resp_data = mem_data_i; state -> IDLE same edge.
REQ-016 Fill latency: accept cycle 0, mem request cycle 1, data_valid cycle 1+MEM_LATENCY, resp_valid cycle 2+MEM_LATENCY, next accept possible cycle 2+MEM_LATENCY.
REQ-017 Writeback throughput: accept every 2 cycles.
REQ-018 WAIT_RD counter counts from 0; reaching TIMEOUT without matching response sets timeout_err_o, returns to IDLE, no response pulse.
REQ-019 mem_data_valid_i in IDLE/ISSUE, or in WAIT_RD with mismatched tag, sets spurious_err_o; data discarded, state unchanged.
REQ-020 resp_data outputs hold last value when resp_valid low.
REQ-021 Error flags sticky until reset; errors never block further requests.

Reset
REQ-022 rst_i low asynchronously forces state DRAIN, drain counter to 0, round-robin pointer to dcache, all valid/ready/resp_valid/error outputs 0, data/address outputs 0.
REQ-023 Reset mid-WAIT_RD: outstanding fill discarded, no response pulse; late memory response absorbed by DRAIN without error.

Verification
REQ-024 Icache fill 0x40 after DRAIN, memory returns 0xA5.. at cycle 11 -> ic_resp_valid_o pulse cycle 12, data 0xA5.., no errors.
REQ-025 ic and dc fills both valid in IDLE after reset -> dc accepted first, ic accepted on next IDLE; each response routed by tag.
REQ-026 Dcache writeback 0x80, data 0x1234.. then dcache fill 0x80 -> mem_wr pulse, accept 2 cycles later, fill returns 0x1234...
REQ-027 Memory model silent for a fill, TIMEOUT=32 -> timeout_err_o high after 32 WAIT_RD cycles, state IDLE, next request accepted.
REQ-028 mem_data_valid_i pulsed in IDLE -> spurious_err_o set, no resp pulse; rst_i low mid-WAIT_RD then late response -> no error, no pulse.
